// File: rtl/maze_flag_engine.sv
// rtl/maze_flag_engine.sv - four-direction free-distance probe of the maze wall map
//
// Takes a sprite position through a valid/ready request and probes the single-port
// wall ROM corner by corner in the order L, U, R, D. Each direction reports how many
// whole pixel steps the sprite may move (0 = blocked, MAX_STEP = saturated).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready position request handshake (ready only while idle)
//   req_x, req_y        sprite top-left pixel, latched at accept
//   rom_addr, rom_data  wall ROM read port; data returns one cycle after the address
//   flag_L/U/R/D        free steps per direction, updated together
//   flag_valid          one-cycle pulse when the flags update
//   busy                high from accept through the flag_valid cycle
module maze_flag_engine #(
    parameter int SPRITE     = 16,
    parameter int TILE_SHIFT = 3,
    parameter int MAP_TW     = 40,
    parameter int MAP_TH     = 30,
    parameter int MAX_STEP   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [8:0]  req_x,
    input  logic [8:0]  req_y,
    output logic [10:0] rom_addr,
    input  logic        rom_data,
    output logic [2:0]  flag_L,
    output logic [2:0]  flag_U,
    output logic [2:0]  flag_R,
    output logic [2:0]  flag_D,
    output logic        flag_valid,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ADDR  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] DIR_L = 2'd0;
    localparam logic [1:0] DIR_U = 2'd1;
    localparam logic [1:0] DIR_R = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    localparam logic signed [9:0] MAP_W_PX = 10'(MAP_TW << TILE_SHIFT);
    localparam logic signed [9:0] MAP_H_PX = 10'(MAP_TH << TILE_SHIFT);
    localparam logic signed [9:0] EDGE     = 10'(SPRITE - 1);
    localparam logic [2:0]        STEP_MAX = 3'(MAX_STEP);

    logic [1:0]        state;
    logic signed [9:0] pos_x;
    logic signed [9:0] pos_y;
    logic [1:0]        dir;
    logic [2:0]        step;
    logic              corner;    // 0 = corner A, 1 = corner B
    logic              a_blk;     // corner A result of the current step
    logic [2:0]        sh_l;
    logic [2:0]        sh_u;
    logic [2:0]        sh_r;

    logic signed [9:0] k_s;
    logic signed [9:0] off;
    logic signed [9:0] px;
    logic signed [9:0] py;
    logic [9:0]        px_u;
    logic [9:0]        py_u;
    logic [9:0]        tx;
    logic [9:0]        ty;
    logic              oob;
    logic [10:0]       addr_c;
    logic              blk_now;
    logic              step_blk;
    logic [2:0]        dir_flag;

    // Probe corner for the current direction, step and corner select.
    always_comb begin
        k_s = signed'({7'b0, step});
        off = corner ? EDGE : 10'sd0;
        px  = pos_x;
        py  = pos_y;
        case (dir)
            DIR_L: begin
                px = pos_x - k_s;
                py = pos_y + off;
            end
            DIR_U: begin
                px = pos_x + off;
                py = pos_y - k_s;
            end
            DIR_R: begin
                px = pos_x + k_s + EDGE;
                py = pos_y + off;
            end
            default: begin
                px = pos_x + off;
                py = pos_y + k_s + EDGE;
            end
        endcase
    end

    // A wrapped (negative) result of the 10-bit arithmetic also lands out of bounds.
    assign oob = (px < 10'sd0) || (px >= MAP_W_PX) || (py < 10'sd0) || (py >= MAP_H_PX);

    assign px_u   = px;
    assign py_u   = py;
    assign tx     = px_u >> TILE_SHIFT;
    assign ty     = py_u >> TILE_SHIFT;
    assign addr_c = 11'(ty) * 11'(MAP_TW) + 11'(tx);

    // Address is held through CHECK as well so the ROM sees a stable value.
    assign rom_addr = ((state == S_ADDR || state == S_CHECK) && !oob) ? addr_c : 11'd0;

    assign req_ready = (state == S_IDLE);

    // Out-of-bounds overrides whatever the ROM returned for address 0.
    assign blk_now  = oob || rom_data;
    assign step_blk = a_blk || blk_now;
    assign dir_flag = step_blk ? (step - 3'd1) : STEP_MAX;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            pos_x      <= '0;
            pos_y      <= '0;
            dir        <= DIR_L;
            step       <= 3'd1;
            corner     <= 1'b0;
            a_blk      <= 1'b0;
            sh_l       <= '0;
            sh_u       <= '0;
            sh_r       <= '0;
            flag_L     <= '0;
            flag_U     <= '0;
            flag_R     <= '0;
            flag_D     <= '0;
            flag_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        pos_x  <= signed'({1'b0, req_x});
                        pos_y  <= signed'({1'b0, req_y});
                        dir    <= DIR_L;
                        step   <= 3'd1;
                        corner <= 1'b0;
                        a_blk  <= 1'b0;
                        busy   <= 1'b1;
                        state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (!corner) begin
                        // Corner B is always probed so every step costs the same.
                        a_blk  <= blk_now;
                        corner <= 1'b1;
                        state  <= S_ADDR;
                    end else if (!step_blk && step != STEP_MAX) begin
                        step   <= step + 3'd1;
                        corner <= 1'b0;
                        state  <= S_ADDR;
                    end else begin
                        step   <= 3'd1;
                        corner <= 1'b0;
                        case (dir)
                            DIR_L: sh_l <= dir_flag;
                            DIR_U: sh_u <= dir_flag;
                            DIR_R: sh_r <= dir_flag;
                            default: begin
                                flag_L     <= sh_l;
                                flag_U     <= sh_u;
                                flag_R     <= sh_r;
                                flag_D     <= dir_flag;
                                flag_valid <= 1'b1;
                            end
                        endcase
                        if (dir == DIR_D) begin
                            state <= S_DONE;
                        end else begin
                            dir   <= dir + 2'd1;
                            state <= S_ADDR;
                        end
                    end
                end
                default: begin
                    flag_valid <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/maze_flag_engine.md
Name: maze_flag_engine

Overview:
Producer side of the movement-flag interface that sprite movers (monsters, pacman) consume. For a sprite position request it probes the maze wall map step by step in each of the four directions. It returns a 3-bit free-distance flag per direction, so a flag of 0 means blocked. It is time-shared across sprites via a valid/ready request handshake and owns the read port of the single-port tile wall ROM.

Parameters:
SPRITE, 16, sprite square edge in pixels; the position is the sprite's top-left pixel
TILE_SHIFT, 3, log2 of tile edge in pixels (8 px tiles)
MAP_TW, 40, map width in tiles (320 px)
MAP_TH, 30, map height in tiles (240 px)
MAX_STEP, 7, probe depth per direction; also the flag saturation value

Ports:
clk  in  1  system clock; one clock domain
rst  in  1  synchronous reset, active-high
req_valid  in  1  position request valid
req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready
req_x  in  9  sprite x (pixels), sampled at accept
req_y  in  9  sprite y (pixels), sampled at accept
rom_addr  out  11  wall ROM address = ty*MAP_TW + tx
rom_data  in  1  wall bit (1 = wall), valid the cycle after rom_addr is presented
flag_L  out  3  free pixel steps left, 0..7
flag_U  out  3  free pixel steps up, 0..7
flag_R  out  3  free pixel steps right, 0..7
flag_D  out  3  free pixel steps down, 0..7
flag_valid  out  1  one-cycle pulse when all four flags are updated
busy  out  1  high from accept until the flag_valid cycle inclusive

Behaviour:
- Reset (sync, active-high): state IDLE; flag_L/U/R/D = 0; flag_valid = 0; busy = 0; rom_addr = 0; req_ready = 1 from the first cycle after rst deasserts.
- States: IDLE -> ADDR -> CHECK -> (ADDR | DONE) -> IDLE.
- Evaluation order is L, U, R, D. Within a direction, step k runs 1..MAX_STEP. For each step, corner A is probed, then corner B.
- Probe positions, for candidate (x', y') = (x,y) displaced by k in the current direction:
  - L: corners (x', y) and (x', y+SPRITE-1)
  - R: corners (x'+SPRITE-1, y) and (x'+SPRITE-1, y+SPRITE-1)
  - U: corners (x, y') and (x+SPRITE-1, y')
  - D: corners (x, y'+SPRITE-1) and (x+SPRITE-1, y'+SPRITE-1)
- Address arithmetic is done 10-bit signed. A corner is out-of-bounds if its coordinate is < 0, or x >= MAP_TW<<TILE_SHIFT, or y >= MAP_TH<<TILE_SHIFT.
- ADDR: drive rom_addr = (py>>TILE_SHIFT)*MAP_TW + (px>>TILE_SHIFT). For an out-of-bounds corner, drive rom_addr = 0.
- CHECK: the corner is blocked if it is out-of-bounds or rom_data = 1. Out-of-bounds wins, so rom_data is ignored for that corner.
- Every corner costs exactly 2 cycles, for deterministic timing.
- Step k is free only if both corners are free. The first blocked step ends that direction with flag = k-1, and the remaining steps are skipped. If all MAX_STEP steps are free, flag = MAX_STEP.
- Per-direction results go into shadow registers. flag_L/U/R/D all update together in DONE, with flag_valid = 1 for exactly that cycle, then IDLE. Flags hold their value until the next DONE.
- Latency from accept to flag_valid:
  - worst case (all free): 4*7*2*2 + 1 = 113 cycles
  - best case (all blocked at k=1): 4*1*2*2 + 1 = 17 cycles
- req_valid while busy is ignored, not queued. A requester must hold req_valid until it sees req_ready.
- Accept and DONE never coincide, since req_ready is low in DONE.
- Reset asserted mid-evaluation aborts it: next cycle is IDLE, flags = 0, and no flag_valid pulse.
- req_x/req_y may change after accept without effect; they are latched at accept.

Test Plan:
- All-zero ROM, request (100,100) -> after 113 cycles flag_valid pulses once; L=U=R=D=7; busy falls the cycle after.
- Wall only at tile (tx=10, ty=12), i.e. px 80..87, py 96..103; request (91,100) -> flag_L=3, U=7, R=7, D=7.
- All-zero ROM, request (2,0) -> flag_L=2, flag_U=0, flag_R=7, flag_D=7.
- All-zero ROM, request (299,224) -> flag_R=5 (right edge x'+15 <= 319), flag_D=0 (bottom edge 239).
- Second req_valid with a different position while busy -> ignored; only the first result appears. A request presented after return to IDLE is accepted and evaluated.
- rst pulsed 20 cycles after accept -> next cycle busy=0, flags=0, req_ready=1, no flag_valid. A new request then completes normally.
